// File: rtl/load_store_sequencer_pkg.sv
// Shared command/state types and command-class helpers for load_store_sequencer.
package load_store_sequencer_pkg;

  typedef enum logic [3:0] {
    LB  = 4'd0,
    LH  = 4'd1,
    LW  = 4'd2,
    LBU = 4'd3,
    LHU = 4'd4,
    SB  = 4'd5,
    SH  = 4'd6,
    SW  = 4'd7,
    FLW = 4'd8,
    FSW = 4'd9,
    FLD = 4'd10,
    FSD = 4'd11
  } LsuOp;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TLB,
    S_MEM,
    S_WAIT,
    S_DONE,
    S_FLUSH
  } LsuState;

  function automatic logic isStore(input LsuOp op);
    return (op == SB) || (op == SH) || (op == SW) || (op == FSW) || (op == FSD);
  endfunction

  function automatic logic isFp64(input LsuOp op);
    return (op == FLD) || (op == FSD);
  endfunction

endpackage

// File: rtl/load_store_sequencer_load_align.sv
// Combinational load-lane select plus sign/zero/NaN-box extension to 64 bits.
module lsu_load_align
  import load_store_sequencer_pkg::*;
(
  input  LsuOp        op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [63:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{offset, 3'b000} +: 8];
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    result    = '0;
    case (op)
      LB:      result = {{56{byte_lane[7]}}, byte_lane};
      LH:      result = {{48{half_lane[15]}}, half_lane};
      LW:      result = {{32{rdata[31]}}, rdata};
      LBU:     result = {56'd0, byte_lane};
      LHU:     result = {48'd0, half_lane};
      FLW:     result = {32'hFFFF_FFFF, rdata};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// Execute-stage load/store responder: address generation, TLB lookup and data-memory handshake.
// Define LSU_FP64_EN to run FLD/FSD as two-beat accesses; otherwise they complete as no-ops.
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                enable,
  input  logic                invalidateTlb,
  input  logic [3:0]          command,
  input  logic [31:0]         imm,
  input  logic [31:0]         srcIntRegValue1,
  input  logic [31:0]         srcIntRegValue2,
  input  logic [63:0]         srcFpRegValue2,
  output logic                done,
  output logic                loadPagefault,
  output logic                storePagefault,
  output logic [63:0]         result,
  output logic                tlbReq,
  output logic [ADDR_W-1:0]   tlbVaddr,
  input  logic                tlbDone,
  input  logic                tlbFault,
  input  logic [ADDR_W-1:0]   tlbPaddr,
  output logic                tlbFlush,
  output logic                memReq,
  output logic                memWrite,
  output logic [ADDR_W-1:0]   memAddr,
  output logic [DATA_W-1:0]   memWdata,
  output logic [DATA_W/8-1:0] memBe,
  input  logic                memGnt,
  input  logic                memValid,
  input  logic [DATA_W-1:0]   memRdata
);

  LsuState     state, next_state;
  LsuOp        op_q, cmd_op;
  logic [31:0] vaddr_q, paddr_q, int_data_q, lo_q;
  logic [63:0] fp_data_q, result_q, aligned;
  logic        beat_q, load_fault_q, store_fault_q;

  assign cmd_op = LsuOp'(command);

  lsu_load_align u_align (
    .op     (op_q),
    .offset (paddr_q[1:0]),
    .rdata  (memRdata),
    .result (aligned)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    done       = 1'b0;
    tlbReq     = 1'b0;
    tlbFlush   = 1'b0;
    memReq     = 1'b0;
    memWrite   = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          if (invalidateTlb) begin
            next_state = S_FLUSH;
          end else begin
            next_state = S_TLB;
`ifndef LSU_FP64_EN
            if (isFp64(cmd_op)) next_state = S_DONE;
`endif
          end
        end
      end
      S_FLUSH: begin
        tlbFlush   = 1'b1;
        next_state = S_DONE;
      end
      S_TLB: begin
        tlbReq = 1'b1;
        if (tlbDone) next_state = tlbFault ? S_DONE : S_MEM;
      end
      S_MEM: begin
        memReq   = 1'b1;
        memWrite = isStore(op_q);
        if (memGnt) next_state = S_WAIT;
      end
      S_WAIT: begin
        // A two-beat access returns to MEM for its upper word.
        if (memValid) next_state = (isFp64(op_q) && !beat_q) ? S_MEM : S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op_q          <= LB;
      vaddr_q       <= '0;
      paddr_q       <= '0;
      int_data_q    <= '0;
      fp_data_q     <= '0;
      lo_q          <= '0;
      beat_q        <= 1'b0;
      result_q      <= '0;
      load_fault_q  <= 1'b0;
      store_fault_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            load_fault_q  <= 1'b0;
            store_fault_q <= 1'b0;
            if (!invalidateTlb) begin
              op_q       <= cmd_op;
              vaddr_q    <= srcIntRegValue1 + imm;
              int_data_q <= srcIntRegValue2;
              fp_data_q  <= srcFpRegValue2;
              beat_q     <= 1'b0;
              result_q   <= '0;
            end
          end
        end
        S_TLB: begin
          if (tlbDone) begin
            paddr_q       <= tlbPaddr;
            load_fault_q  <= tlbFault && !isStore(op_q);
            store_fault_q <= tlbFault && isStore(op_q);
          end
        end
        S_WAIT: begin
          if (memValid) begin
            if (isFp64(op_q) && !beat_q) begin
              lo_q   <= memRdata;
              beat_q <= 1'b1;
            end else if (!isStore(op_q)) begin
              result_q <= isFp64(op_q) ? {memRdata, lo_q} : aligned;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Byte lanes and store replication follow the translated address, never the virtual one.
  always_comb begin
    memAddr  = isFp64(op_q) ? {paddr_q[31:3], beat_q, 2'b00} : {paddr_q[31:2], 2'b00};
    memBe    = 4'hF;
    memWdata = int_data_q;
    case (op_q)
      SB: begin
        memBe    = 4'b0001 << paddr_q[1:0];
        memWdata = {4{int_data_q[7:0]}};
      end
      SH: begin
        memBe    = paddr_q[1] ? 4'b1100 : 4'b0011;
        memWdata = {2{int_data_q[15:0]}};
      end
      FSW:     memWdata = fp_data_q[31:0];
      FSD:     memWdata = beat_q ? fp_data_q[63:32] : fp_data_q[31:0];
      default: ;
    endcase
  end

  assign tlbVaddr       = vaddr_q;
  assign result         = result_q;
  assign loadPagefault  = load_fault_q;
  assign storePagefault = store_fault_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Self-checking bench for load_store_sequencer: spec vector table, mid-operation reset, random ops vs model.
module tb_load_store_sequencer;
  import load_store_sequencer_pkg::*;

`ifdef LSU_FP64_EN
  localparam bit FP64_EN = 1'b1;
`else
  localparam bit FP64_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN, enable, invalidateTlb;
  logic [3:0]  command;
  logic [31:0] imm, srcIntRegValue1, srcIntRegValue2;
  logic [63:0] srcFpRegValue2;
  logic        done, loadPagefault, storePagefault;
  logic [63:0] result;
  logic        tlbReq, tlbDone, tlbFault, tlbFlush;
  logic [31:0] tlbVaddr, tlbPaddr;
  logic        memReq, memWrite, memGnt, memValid;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memBe;

  always #5 clk = ~clk;

  load_store_sequencer dut (
    .clk(clk), .rstN(rstN), .enable(enable), .invalidateTlb(invalidateTlb), .command(command),
    .imm(imm), .srcIntRegValue1(srcIntRegValue1), .srcIntRegValue2(srcIntRegValue2),
    .srcFpRegValue2(srcFpRegValue2), .done(done), .loadPagefault(loadPagefault),
    .storePagefault(storePagefault), .result(result), .tlbReq(tlbReq), .tlbVaddr(tlbVaddr),
    .tlbDone(tlbDone), .tlbFault(tlbFault), .tlbPaddr(tlbPaddr), .tlbFlush(tlbFlush),
    .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memGnt(memGnt), .memValid(memValid), .memRdata(memRdata)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] base, offs, idata;
    logic [63:0] fdata;
    logic        inv, fault;
    int          gdelay;
    logic [31:0] mask, rd0, rd1;
    int          exp_done;
    logic [63:0] exp_result;
    logic        exp_lf, exp_sf;
    int          exp_beats;
    logic [31:0] exp_addr0, exp_addr1, exp_wdata0, exp_wdata1;
    logic [3:0]  exp_be0;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int          obs_done_cyc, obs_beats, obs_unstable, obs_flush_cnt, obs_flush_cyc, obs_tlb_cnt;
  logic [63:0] obs_result;
  logic        obs_lf, obs_sf;
  logic [31:0] obs_vaddr;
  logic [31:0] obs_addr[2], obs_wdata[2];
  logic [3:0]  obs_be[2];
  logic        obs_write[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic is_store(input logic [3:0] op);
    LsuOp o = LsuOp'(op);
    return o inside {SB, SH, SW, FSW, FSD};
  endfunction

  function automatic logic is_fp64(input logic [3:0] op);
    LsuOp o = LsuOp'(op);
    return o inside {FLD, FSD};
  endfunction

  // Reference model: expected outcome of one command from the access rules alone.
  function automatic vec_t model(input vec_t v, input logic [63:0] prev);
    vec_t        e = v;
    logic [31:0] va, pa, off, sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic        st = is_store(v.op);
    logic        fp = is_fp64(v.op);
    va = v.base + v.offs;
    pa = va ^ v.mask;
    off = pa % 32'd4;
    e.exp_lf = 1'b0; e.exp_sf = 1'b0; e.exp_beats = 0; e.exp_result = '0;
    e.exp_addr0 = '0; e.exp_addr1 = '0; e.exp_wdata0 = '0; e.exp_wdata1 = '0; e.exp_be0 = 4'hF;
    if (v.inv) begin
      e.exp_done = 2;
      e.exp_result = prev;
    end else if (fp && !FP64_EN) begin
      e.exp_done = 1;
    end else if (v.fault) begin
      e.exp_done = 2;
      e.exp_lf = !st;
      e.exp_sf = st;
    end else begin
      e.exp_beats = fp ? 2 : 1;
      e.exp_done = 2 + e.exp_beats * (v.gdelay + 2);
      e.exp_addr0 = fp ? pa - (pa % 32'd8) : pa - off;
      e.exp_addr1 = e.exp_addr0 + 32'd4;
      sh = v.rd0 >> (32'd8 * off);
      b = sh[7:0];
      sh = v.rd0 >> ((off >= 32'd2) ? 16 : 0);
      h = sh[15:0];
      case (LsuOp'(v.op))
        LB:  e.exp_result = {{56{b[7]}}, b};
        LH:  e.exp_result = {{48{h[15]}}, h};
        LW:  e.exp_result = {{32{v.rd0[31]}}, v.rd0};
        LBU: e.exp_result = {56'd0, b};
        LHU: e.exp_result = {48'd0, h};
        FLW: e.exp_result = {32'hFFFF_FFFF, v.rd0};
        FLD: e.exp_result = {v.rd1, v.rd0};
        default: e.exp_result = '0;
      endcase
      case (LsuOp'(v.op))
        SB: begin e.exp_be0 = 4'b0001 << off; e.exp_wdata0 = v.idata[7:0] * 32'h0101_0101; end
        SH: begin e.exp_be0 = (off >= 32'd2) ? 4'b1100 : 4'b0011; e.exp_wdata0 = v.idata[15:0] * 32'h0001_0001; end
        SW:  e.exp_wdata0 = v.idata;
        FSW: e.exp_wdata0 = v.fdata[31:0];
        FSD: begin e.exp_wdata0 = v.fdata[31:0]; e.exp_wdata1 = v.fdata[63:32]; end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Drives one command and plays TLB/memory responder until done or the cycle budget runs out.
  task automatic applyStimulus(input vec_t v);
    int          req_len = 0;
    logic        valid_due = 1'b0;
    logic [31:0] f_addr = '0, f_wdata = '0;
    logic [3:0]  f_be = '0;
    logic        f_write = 1'b0;
    obs_done_cyc = -1; obs_beats = 0; obs_unstable = 0; obs_flush_cnt = 0; obs_flush_cyc = -1;
    obs_tlb_cnt = 0; obs_result = '0; obs_lf = 1'b0; obs_sf = 1'b0; obs_vaddr = '0;
    for (int i = 0; i < 2; i++) begin
      obs_addr[i] = '0; obs_wdata[i] = '0; obs_be[i] = '0; obs_write[i] = 1'b0;
    end
    @(negedge clk);
    chk("done_low_before_accept", 64'(done), 64'd0);
    enable = 1'b1; invalidateTlb = v.inv; command = v.op; imm = v.offs;
    srcIntRegValue1 = v.base; srcIntRegValue2 = v.idata; srcFpRegValue2 = v.fdata;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      tlbDone = 1'b0; tlbFault = 1'b0; memGnt = 1'b0; memValid = 1'b0;
      if (valid_due) begin
        memValid = 1'b1;
        memRdata = (obs_beats == 1) ? v.rd0 : v.rd1;
        valid_due = 1'b0;
      end
      if (done) begin
        obs_done_cyc = k; obs_result = result; obs_lf = loadPagefault; obs_sf = storePagefault;
        break;
      end
      if (tlbFlush) begin obs_flush_cnt++; obs_flush_cyc = k; end
      if (tlbReq) begin
        obs_tlb_cnt++;
        obs_vaddr = tlbVaddr;
        tlbDone = 1'b1; tlbFault = v.fault; tlbPaddr = tlbVaddr ^ v.mask;
      end
      if (memReq) begin
        if (req_len == 0) begin
          f_addr = memAddr; f_be = memBe; f_wdata = memWdata; f_write = memWrite;
        end else if (memAddr !== f_addr || memBe !== f_be || memWdata !== f_wdata || memWrite !== f_write) begin
          obs_unstable++;
        end
        if (req_len == v.gdelay) begin
          memGnt = 1'b1;
          if (obs_beats < 2) begin
            obs_addr[obs_beats] = memAddr; obs_be[obs_beats] = memBe;
            obs_wdata[obs_beats] = memWdata; obs_write[obs_beats] = memWrite;
          end
          obs_beats++;
          valid_due = 1'b1;
          req_len = 0;
        end else begin
          req_len++;
        end
      end
      @(posedge clk);
    end
    enable = 1'b0; invalidateTlb = 1'b0;
    tlbDone = 1'b0; tlbFault = 1'b0; memGnt = 1'b0; memValid = 1'b0;
  endtask

  task automatic checkOutput(input vec_t e, input string tag);
    logic exp_tlb = !e.inv && (e.exp_done != 1);
    chk({tag, "_done_cycle"}, 64'(obs_done_cyc), 64'(e.exp_done));
    chk({tag, "_result"}, obs_result, e.exp_result);
    chk({tag, "_load_fault"}, 64'(obs_lf), 64'(e.exp_lf));
    chk({tag, "_store_fault"}, 64'(obs_sf), 64'(e.exp_sf));
    chk({tag, "_beats"}, 64'(obs_beats), 64'(e.exp_beats));
    chk({tag, "_req_stable"}, 64'(obs_unstable), 64'd0);
    chk({tag, "_tlb_reqs"}, 64'(obs_tlb_cnt), 64'(exp_tlb));
    if (exp_tlb && obs_tlb_cnt > 0) chk({tag, "_vaddr"}, 64'(obs_vaddr), 64'(e.base + e.offs));
    if (e.exp_beats > 0 && obs_beats > 0) begin
      chk({tag, "_addr0"}, 64'(obs_addr[0]), 64'(e.exp_addr0));
      chk({tag, "_write0"}, 64'(obs_write[0]), 64'(is_store(e.op)));
      if (is_store(e.op)) begin
        chk({tag, "_be0"}, 64'(obs_be[0]), 64'(e.exp_be0));
        chk({tag, "_wdata0"}, 64'(obs_wdata[0]), 64'(e.exp_wdata0));
      end
    end
    if (e.exp_beats > 1 && obs_beats > 1) begin
      chk({tag, "_addr1"}, 64'(obs_addr[1]), 64'(e.exp_addr1));
      if (is_store(e.op)) chk({tag, "_wdata1"}, 64'(obs_wdata[1]), 64'(e.exp_wdata1));
    end
    if (e.inv) chk({tag, "_flush_cycle"}, 64'(obs_flush_cyc), 64'd1);
    chk({tag, "_flush_pulses"}, 64'(obs_flush_cnt), 64'(e.inv));
  endtask

  task automatic do_reset();
    rstN = 1'b0; enable = 1'b0; invalidateTlb = 1'b0; command = '0; imm = '0;
    srcIntRegValue1 = '0; srcIntRegValue2 = '0; srcFpRegValue2 = '0;
    tlbDone = 1'b0; tlbFault = 1'b0; tlbPaddr = '0; memGnt = 1'b0; memValid = 1'b0; memRdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_faults", 64'({loadPagefault, storePagefault}), 64'd0);
    chk("rst_requests", 64'({tlbReq, tlbFlush, memReq, memWrite}), 64'd0);
    chk("rst_result", result, 64'd0);
    rstN = 1'b1;
  endtask

  // Reset asserted while a data request is outstanding; a late memValid must not complete anything.
  task automatic reset_mid_op();
    int   target = FP64_EN ? 2 : 1;
    int   hits = 0;
    logic valid_due = 1'b0;
    logic reached = 1'b0;
    logic stale = 1'b0;
    @(negedge clk);
    enable = 1'b1; command = FP64_EN ? 4'(FLD) : 4'(LW); srcIntRegValue1 = 32'h4000; imm = '0;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      tlbDone = 1'b0; memGnt = 1'b0; memValid = 1'b0;
      if (valid_due) begin memValid = 1'b1; memRdata = 32'h1111_1111; valid_due = 1'b0; end
      if (tlbReq) begin tlbDone = 1'b1; tlbPaddr = tlbVaddr; end
      if (memReq) begin
        hits++;
        if (hits == target) begin reached = 1'b1; break; end
        memGnt = 1'b1;
        valid_due = 1'b1;
      end
      @(posedge clk);
    end
    chk("midrst_reached_mem", 64'(reached), 64'd1);
    rstN = 1'b0;
    #1;
    chk("midrst_requests_drop", 64'({tlbReq, memReq, memWrite, done}), 64'd0);
    chk("midrst_result", result, 64'd0);
    enable = 1'b0; tlbDone = 1'b0; memGnt = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    memValid = 1'b1; memRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    memValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done || result != 64'd0 || memReq || tlbReq) stale = 1'b1;
      @(negedge clk);
    end
    chk("midrst_stale_valid_ignored", 64'(stale), 64'd0);
  endtask

  function automatic vec_t mk(input LsuOp op, input logic [31:0] base, offs, idata, input logic [63:0] fdata,
                              input logic inv, fault, input int gdelay, input logic [31:0] mask, rd0, rd1);
    vec_t v;
    v.op = op; v.base = base; v.offs = offs; v.idata = idata; v.fdata = fdata; v.inv = inv;
    v.fault = fault; v.gdelay = gdelay; v.mask = mask; v.rd0 = rd0; v.rd1 = rd1;
    v.exp_done = 0; v.exp_result = '0; v.exp_lf = 1'b0; v.exp_sf = 1'b0; v.exp_beats = 0;
    v.exp_addr0 = '0; v.exp_addr1 = '0; v.exp_wdata0 = '0; v.exp_wdata1 = '0; v.exp_be0 = 4'hF;
    return v;
  endfunction

  initial begin
    vec_t        vecs[8];
    vec_t        v, e;
    logic [63:0] prev;
    do_reset();

    vecs[0] = mk(LW, 32'h1000, 32'h4, 0, 0, 0, 0, 0, 0, 32'h8000_0001, 0);
    vecs[0].exp_done = 4; vecs[0].exp_result = 64'hFFFF_FFFF_8000_0001; vecs[0].exp_beats = 1;
    vecs[0].exp_addr0 = 32'h1004;
    vecs[1] = mk(SB, 32'h2003, 0, 32'hAB, 0, 0, 0, 0, 0, 0, 0);
    vecs[1].exp_done = 4; vecs[1].exp_beats = 1; vecs[1].exp_addr0 = 32'h2000;
    vecs[1].exp_be0 = 4'b1000; vecs[1].exp_wdata0 = 32'hABAB_ABAB;
    vecs[2] = mk(LBU, 32'h3002, 0, 0, 0, 0, 0, 3, 0, 32'h00FF_0000, 0);
    vecs[2].exp_done = 7; vecs[2].exp_result = 64'hFF; vecs[2].exp_beats = 1; vecs[2].exp_addr0 = 32'h3000;
    vecs[3] = mk(LW, 32'h9999, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3].exp_done = 2; vecs[3].exp_result = 64'hFF;
    vecs[4] = mk(SW, 32'h5000, 0, 32'h1234_5678, 0, 0, 1, 0, 0, 0, 0);
    vecs[4].exp_done = 2; vecs[4].exp_sf = 1'b1;
    vecs[5] = mk(LH, 32'h6000, 32'h12, 0, 0, 0, 0, 1, 32'h0F00_0000, 32'h8001_1234, 0);
    vecs[5].exp_done = 5; vecs[5].exp_result = 64'hFFFF_FFFF_FFFF_8001; vecs[5].exp_beats = 1;
    vecs[5].exp_addr0 = 32'h0F00_6010;
    vecs[6] = mk(SH, 32'h7001, 0, 32'h1234_BEEF, 0, 0, 0, 0, 0, 0, 0);
    vecs[6].exp_done = 4; vecs[6].exp_beats = 1; vecs[6].exp_addr0 = 32'h7000;
    vecs[6].exp_be0 = 4'b0011; vecs[6].exp_wdata0 = 32'hBEEF_BEEF;
    vecs[7] = mk(FLD, 32'h4000, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h2222_2222);
`ifdef LSU_FP64_EN
    vecs[7].exp_done = 6; vecs[7].exp_result = 64'h2222_2222_1111_1111; vecs[7].exp_beats = 2;
    vecs[7].exp_addr0 = 32'h4000; vecs[7].exp_addr1 = 32'h4004;
`else
    vecs[7].exp_done = 1;
`endif

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("tbl%0d", i));
    end

    reset_mid_op();
    do_reset();

    prev = '0;
    for (int i = 0; i < 40; i++) begin
      v = mk(LsuOp'($urandom_range(0, 11)), $urandom, $urandom_range(0, 255), $urandom,
             {$urandom, $urandom}, ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
             $urandom_range(0, 2), $urandom & 32'hFFFF_F000 | ($urandom & 32'h7), $urandom, $urandom);
      e = model(v, prev);
      applyStimulus(e);
      checkOutput(e, $sformatf("rnd%0d", i));
      prev = e.exp_result;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
